sys_ctrl_rx_decoder: RTL
========================

# sys_ctrl_rx_decoder

Fast-domain command decoder sitting directly downstream of the slow-to-fast byte synchronizer on the UART RX path. It consumes synchronized bytes, each qualified by a one-cycle valid pulse. It parses them into register-file write/read and ALU commands, then drives the register file and ALU. It returns read data and ALU results byte-wise to the TX path through a valid/busy handshake.

## Interface
- Width, 8, data byte width
- ADDR_W, 4, register-file address width
- FUN_W, 4, ALU function code width
- TIMEOUT_CYCLES, 4096, inter-byte timeout in CLK cycles (used only with the timeout feature)

- CLK  in  1  fast system clock
- Reset  in  1  asynchronous, active-low reset
- rx_data  in  Width  synchronized byte, stable when rx_valid high
- rx_valid  in  1  one-cycle pulse per received byte
- rf_addr  out  ADDR_W  register-file address
- rf_wr_data  out  Width  register-file write data
- rf_wr_en  out  1  one-cycle write strobe
- rf_rd_en  out  1  read request, held until rf_rd_valid
- rf_rd_data  in  Width  read data
- rf_rd_valid  in  1  read data valid pulse
- alu_fun  out  FUN_W  ALU function
- alu_en  out  1  one-cycle ALU start strobe
- alu_clk_gate_en  out  1  ALU clock-gate enable
- alu_out  in  2*Width  ALU result
- alu_out_valid  in  1  result valid pulse
- tx_data  out  Width  response byte
- tx_valid  out  1  response byte valid
- tx_busy  in  1  TX path busy
- cmd_error  out  1  one-cycle error pulse

## Operation
- Commands by first byte:
  - 0xAA, then addr, then data: RF write.
  - 0xBB, then addr: RF read; 1 response byte.
  - 0xCC, then A, B, fun: A is written to addr 0, B to addr 1, then the ALU starts; 2 response bytes.
  - 0xDD, then fun: ALU run on current operands; 2 response bytes.
- Address bytes use the low ADDR_W bits; fun bytes use the low FUN_W bits.
- States and transitions:
  - IDLE: moves on a valid opcode.
  - WR_ADDR, WR_DATA: RF write bytes.
  - RD_ADDR, RD_WAIT: RF read and wait for data.
  - ALU_A, ALU_B, ALU_FUN, ALU_WAIT: ALU operands, function, wait for result.
  - TX_LO, TX_HI: response bytes.
- Unknown opcode in IDLE: cmd_error pulse, remain in IDLE.
- rx_valid while in RD_WAIT, ALU_WAIT, TX_LO or TX_HI: byte dropped, cmd_error pulse, state unchanged.
- RF read response: rf_rd_en asserted in RD_WAIT, deasserted the cycle after rf_rd_valid; rf_rd_data is captured, sent as one byte in TX_LO, then IDLE.
- ALU response: alu_out captured on alu_out_valid; low byte sent in TX_LO, high byte in TX_HI, then IDLE.
- alu_clk_gate_en: set on fun-byte receipt, cleared the cycle after alu_out_valid.
- TX handshake: a byte transfers in a cycle with tx_valid=1 and tx_busy=0. tx_valid and tx_data are held stable until that transfer. tx_valid drops (or the next byte is presented) the following cycle.

## Timing
- Reset: every output is 0 and the state is IDLE. Reset mid-command discards the partial frame; no strobes are issued.
- rf_wr_en rises 1 cycle after rx_valid of the data byte (0xAA) or of the A/B byte (0xCC). rf_addr and rf_wr_data are valid in the same cycle.
- alu_en rises 1 cycle after rx_valid of the fun byte. alu_clk_gate_en rises in the same cycle and stays high at least until alu_en falls.
- rf_rd_en rises 1 cycle after rx_valid of the addr byte.
- tx_valid rises 1 cycle after rf_rd_valid / alu_out_valid.
- Back-to-back rx_valid on consecutive cycles is accepted; one byte is consumed per pulse.
- rf_rd_valid or alu_out_valid outside the matching wait state is ignored.

## Configuration
- CMD_TIMEOUT_EN defined:
  - A counter runs in WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN and restarts on every rx_valid.
  - After TIMEOUT_CYCLES cycles without a byte: cmd_error pulse, return to IDLE, no strobes issued.
- Not defined: these states wait indefinitely; no counter logic is present.

## Structure
- Shared package:
  - opcode constants 0xAA/0xBB/0xCC/0xDD
  - state enum
  - operand register addresses 0 and 1
- One sub-module, cmd_timeout_cnt (clear, enable, expired pulse), instantiated only under CMD_TIMEOUT_EN.

## Test plan
- AA,05,3C -> one rf_wr_en pulse with rf_addr=5, rf_wr_data=0x3C, 1 cycle after the last rx_valid; no tx_valid.
- BB,02; rf_rd_data=0x7E valid 3 cycles later -> rf_rd_en held until then; tx_data=0x7E with tx_valid held while tx_busy=1, transferred once tx_busy=0.
- CC,12,34,01; alu_out=0x0046 -> writes 0x12@0 and 0x34@1, then alu_en with alu_fun=1; tx bytes 0x46 then 0x00; alu_clk_gate_en deasserted after the result.
- Byte 0x55 in IDLE -> one cmd_error pulse, state IDLE; a following AA frame completes normally.
- With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: AA,05, then silence -> cmd_error at cycle 16, no rf_wr_en; without the macro, a late 3C completes the write.
- Reset asserted after CC,12 -> all outputs 0; a subsequent DD,03 issues alu_en with alu_fun=3.

Source files
------------

// File: rtl/sys_ctrl_rx_decoder_pkg.sv
// Shared definitions for the RX command decoder: opcodes, FSM states and
// the register-file addresses that hold the ALU operands.
package sys_ctrl_rx_decoder_pkg;

  localparam logic [7:0] OP_RF_WR  = 8'hAA;
  localparam logic [7:0] OP_RF_RD  = 8'hBB;
  localparam logic [7:0] OP_ALU_LD = 8'hCC;
  localparam logic [7:0] OP_ALU_GO = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    ALU_A,
    ALU_B,
    ALU_FUN,
    ALU_WAIT,
    TX_LO,
    TX_HI
  } state_e;

endpackage

// File: rtl/sys_ctrl_rx_decoder_if.sv
// Bus bundle between the RX command decoder and its register file, ALU,
// byte synchronizer and TX path. master = decoder side, slave = environment.
interface sys_ctrl_rx_decoder_if #(
  parameter int Width  = 8,
  parameter int ADDR_W = 4,
  parameter int FUN_W  = 4
);
  logic [Width-1:0]   rx_data;
  logic               rx_valid;
  logic [ADDR_W-1:0]  rf_addr;
  logic [Width-1:0]   rf_wr_data;
  logic               rf_wr_en;
  logic               rf_rd_en;
  logic [Width-1:0]   rf_rd_data;
  logic               rf_rd_valid;
  logic [FUN_W-1:0]   alu_fun;
  logic               alu_en;
  logic               alu_clk_gate_en;
  logic [2*Width-1:0] alu_out;
  logic               alu_out_valid;
  logic [Width-1:0]   tx_data;
  logic               tx_valid;
  logic               tx_busy;
  logic               cmd_error;

  modport master (
    input  rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_busy,
    output rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, alu_fun, alu_en, alu_clk_gate_en,
           tx_data, tx_valid, cmd_error
  );

  modport slave (
    output rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_busy,
    input  rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, alu_fun, alu_en, alu_clk_gate_en,
           tx_data, tx_valid, cmd_error
  );

endinterface

// File: rtl/sys_ctrl_rx_decoder_cmd_timeout_cnt.sv
// Inter-byte timeout counter. Counts enabled cycles since the last clear and
// raises a one-cycle expired pulse when LIMIT cycles pass without a clear.
module cmd_timeout_cnt #(
  parameter int LIMIT = 4096
) (
  input  logic CLK,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  assign expired = enable && !clear && (count == CW'(LIMIT - 1));

  // Count idle cycles; a clear or the expiry itself restarts the window.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (clear || expired) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sys_ctrl_rx_decoder.sv
// RX command decoder: parses synchronized bytes into register-file and ALU
// commands and returns read data / ALU results byte-wise to the TX path.
// Optional inter-byte timeout is built when CMD_TIMEOUT_EN is defined.
module sys_ctrl_rx_decoder
  import sys_ctrl_rx_decoder_pkg::*;
#(
  parameter int Width  = 8,
  parameter int ADDR_W = 4,
  parameter int FUN_W  = 4
`ifdef CMD_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic CLK,
  input  logic Reset,
  sys_ctrl_rx_decoder_if.master bus
);

  state_e             state;
  logic               two_byte;
  logic [Width-1:0]   hi_byte;
  logic [ADDR_W-1:0]  rf_addr;
  logic [Width-1:0]   rf_wr_data;
  logic               rf_wr_en;
  logic               rf_rd_en;
  logic [FUN_W-1:0]   alu_fun;
  logic               alu_en;
  logic               alu_clk_gate_en;
  logic [Width-1:0]   tx_data;
  logic               tx_valid;
  logic               cmd_error;
  logic               timeout_hit;

  assign bus.rf_addr         = rf_addr;
  assign bus.rf_wr_data      = rf_wr_data;
  assign bus.rf_wr_en        = rf_wr_en;
  assign bus.rf_rd_en        = rf_rd_en;
  assign bus.alu_fun         = alu_fun;
  assign bus.alu_en          = alu_en;
  assign bus.alu_clk_gate_en = alu_clk_gate_en;
  assign bus.tx_data         = tx_data;
  assign bus.tx_valid        = tx_valid;
  assign bus.cmd_error       = cmd_error;

`ifdef CMD_TIMEOUT_EN
  logic collecting;

  // States that are waiting for the next byte of a frame.
  assign collecting = (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR) ||
                      (state == ALU_A)   || (state == ALU_B)   || (state == ALU_FUN);

  cmd_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .CLK     (CLK),
    .Reset   (Reset),
    .clear   (bus.rx_valid || !collecting),
    .enable  (collecting),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Command FSM with all outputs registered.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state           <= IDLE;
      two_byte        <= 1'b0;
      hi_byte         <= '0;
      rf_addr         <= '0;
      rf_wr_data      <= '0;
      rf_wr_en        <= 1'b0;
      rf_rd_en        <= 1'b0;
      alu_fun         <= '0;
      alu_en          <= 1'b0;
      alu_clk_gate_en <= 1'b0;
      tx_data         <= '0;
      tx_valid        <= 1'b0;
      cmd_error       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the strobes default low here
      // so each branch only has to raise them for the single cycle they apply.
      rf_wr_en  <= 1'b0;
      alu_en    <= 1'b0;
      cmd_error <= 1'b0;

      if (timeout_hit) begin
        state     <= IDLE;
        cmd_error <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (bus.rx_valid) begin
              case (bus.rx_data)
                OP_RF_WR:  state <= WR_ADDR;
                OP_RF_RD:  state <= RD_ADDR;
                OP_ALU_LD: state <= ALU_A;
                OP_ALU_GO: state <= ALU_FUN;
                default:   cmd_error <= 1'b1;
              endcase
            end
          end

          WR_ADDR: begin
            if (bus.rx_valid) begin
              rf_addr <= bus.rx_data[ADDR_W-1:0];
              state   <= WR_DATA;
            end
          end

          WR_DATA: begin
            if (bus.rx_valid) begin
              rf_wr_data <= bus.rx_data;
              rf_wr_en   <= 1'b1;
              state      <= IDLE;
            end
          end

          RD_ADDR: begin
            if (bus.rx_valid) begin
              rf_addr  <= bus.rx_data[ADDR_W-1:0];
              rf_rd_en <= 1'b1;
              state    <= RD_WAIT;
            end
          end

          RD_WAIT: begin
            if (bus.rx_valid) cmd_error <= 1'b1;
            if (bus.rf_rd_valid) begin
              rf_rd_en <= 1'b0;
              tx_data  <= bus.rf_rd_data;
              tx_valid <= 1'b1;
              two_byte <= 1'b0;
              state    <= TX_LO;
            end
          end

          ALU_A: begin
            if (bus.rx_valid) begin
              rf_addr    <= ADDR_W'(OPA_ADDR);
              rf_wr_data <= bus.rx_data;
              rf_wr_en   <= 1'b1;
              state      <= ALU_B;
            end
          end

          ALU_B: begin
            if (bus.rx_valid) begin
              rf_addr    <= ADDR_W'(OPB_ADDR);
              rf_wr_data <= bus.rx_data;
              rf_wr_en   <= 1'b1;
              state      <= ALU_FUN;
            end
          end

          ALU_FUN: begin
            if (bus.rx_valid) begin
              alu_fun         <= bus.rx_data[FUN_W-1:0];
              alu_en          <= 1'b1;
              alu_clk_gate_en <= 1'b1;
              state           <= ALU_WAIT;
            end
          end

          ALU_WAIT: begin
            if (bus.rx_valid) cmd_error <= 1'b1;
            if (bus.alu_out_valid) begin
              alu_clk_gate_en <= 1'b0;
              tx_data         <= bus.alu_out[Width-1:0];
              hi_byte         <= bus.alu_out[2*Width-1:Width];
              tx_valid        <= 1'b1;
              two_byte        <= 1'b1;
              state           <= TX_LO;
            end
          end

          TX_LO: begin
            if (bus.rx_valid) cmd_error <= 1'b1;
            if (!bus.tx_busy) begin
              if (two_byte) begin
                tx_data <= hi_byte;
                state   <= TX_HI;
              end else begin
                tx_valid <= 1'b0;
                state    <= IDLE;
              end
            end
          end

          TX_HI: begin
            if (bus.rx_valid) cmd_error <= 1'b1;
            if (!bus.tx_busy) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
